// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: elastic valid/ready pipeline register with a 2-entry skid buffer.
//
// Carries one opaque payload word between two pipeline stages. The main entry drives the
// output. The skid entry catches the beat accepted in the cycle the output stalls, so
// in_ready_o can come straight from a flop. flush_i synchronously empties the stage.
//
// Ports:
//   clk               rising-edge clock
//   rst               asynchronous, active-high reset
//   flush_i           synchronous kill of held and incoming entries
//   in_valid_i        upstream payload valid
//   in_ready_o        stage can accept this cycle (registered)
//   in_data_i         upstream payload
//   out_valid_o       output payload valid (registered)
//   out_ready_i       downstream accepts this cycle
//   out_data_o        payload; NOP_VALUE whenever out_valid_o is low
//   occupancy_o       number of held entries, 0..2
//   perf_stall_cnt_o  saturating count of stalled-output cycles (PIPE_STAGE_PERF_EN only)
//   perf_bubble_cnt_o saturating count of bubble cycles (PIPE_STAGE_PERF_EN only)
//
// Optional feature: define PIPE_STAGE_PERF_EN to add the two performance counters.

module pipe_stage_elastic #(
  parameter int unsigned       DATA_W    = 32,
  parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}},
  parameter int unsigned       CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occupancy_o
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]  perf_stall_cnt_o,
  output logic [CNT_W-1:0]  perf_bubble_cnt_o
`endif
);

  logic              main_v_q, main_v_d;
  logic              skid_v_q, skid_v_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              ready_q;
  logic              accept, emit;

  assign accept = in_valid_i & ready_q;
  assign emit   = main_v_q & out_ready_i;

  always_comb begin
    main_v_d    = main_v_q;
    skid_v_d    = skid_v_q;
    main_data_d = main_data_q;
    skid_data_d = skid_data_q;
    if (flush_i) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else begin
      unique case ({main_v_q, skid_v_q})
        2'b00: begin
          if (accept) begin
            main_v_d    = 1'b1;
            main_data_d = in_data_i;
          end
        end
        2'b10: begin
          if (emit && accept) begin
            main_data_d = in_data_i;
          end else if (emit) begin
            main_v_d = 1'b0;
          end else if (accept) begin
            skid_v_d    = 1'b1;
            skid_data_d = in_data_i;
          end
        end
        2'b11: begin
          // Full: ready is low so nothing is accepted; skid moves up behind main.
          if (emit) begin
            main_data_d = skid_data_q;
            skid_v_d    = 1'b0;
          end
        end
        default: begin
          // Skid without main cannot occur; recover to empty.
          main_v_d = 1'b0;
          skid_v_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_v_q    <= 1'b0;
      skid_v_q    <= 1'b0;
      main_data_q <= NOP_VALUE;
      skid_data_q <= NOP_VALUE;
      ready_q     <= 1'b0;
    end else begin
      main_v_q    <= main_v_d;
      skid_v_q    <= skid_v_d;
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
      // Ready tracks the next skid state so it is a flop yet equals ~skid_v.
      ready_q     <= ~skid_v_d;
    end
  end

  assign in_ready_o  = ready_q;
  assign out_valid_o = main_v_q;
  assign out_data_o  = main_v_q ? main_data_q : NOP_VALUE;
  assign occupancy_o = {1'b0, main_v_q} + {1'b0, skid_v_q};

`ifdef PIPE_STAGE_PERF_EN
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] bubble_cnt_q;

  // Saturating counters; only rst clears them, flush leaves them alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (main_v_q && !out_ready_i && (stall_cnt_q != CntMax)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (!main_v_q && !flush_i && (bubble_cnt_q != CntMax)) begin
        bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
      end
    end
  end

  assign perf_stall_cnt_o  = stall_cnt_q;
  assign perf_bubble_cnt_o = bubble_cnt_q;
`else
  // Keeps CNT_W referenced when the counters are compiled out.
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised successor to the fixed ID/EX-style stage registers.
- Carries one opaque payload word between two pipeline stages.
- Uses a valid/ready elastic handshake instead of a global stall vector.
- Has a 2-entry skid buffer so in_ready is registered, plus a synchronous flush for branch or jump redirect.
- Every decoupled stage boundary of the next-generation core instantiates this block (IF/ID, ID/EX, EX/MEM, MEM/WB).

Parameters:
- DATA_W, 32, payload width in bits; must be at least 1.
- NOP_VALUE, {DATA_W{1'b0}}, payload driven on out_data whenever out_valid=0 (bubble encoding).
- CNT_W, 32, perf counter width; used only with PIPE_STAGE_PERF_EN.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous kill of all held and incoming entries.
- in_valid  input  1  upstream payload valid.
- in_ready  output  1  stage can accept this cycle; registered.
- in_data  input  DATA_W  upstream payload.
- out_valid  output  1  payload at output is valid; registered.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  DATA_W  payload; equals NOP_VALUE when out_valid=0.
- occupancy  output  2  number of held entries, 0..2.
- perf_stall_cnt  output  CNT_W  present only with PIPE_STAGE_PERF_EN.
- perf_bubble_cnt  output  CNT_W  present only with PIPE_STAGE_PERF_EN.

Behaviour:
- Storage: main entry (main_v, main_d) drives the output; skid entry (skid_v, skid_d) absorbs the beat accepted while the output is stalled.
- Handshakes: accept = in_valid & in_ready; emit = out_valid & out_ready.
- Reset (asynchronous):
  - main_v=0, skid_v=0, occupancy=0, out_valid=0, out_data=NOP_VALUE, perf counters=0.
  - in_ready=0 while rst is high; in_ready=1 from the first clock edge after deassertion.
- Output and ready mapping: in_ready = ~skid_v. out_valid = main_v. out_data = main_v ? main_d : NOP_VALUE.
- States, encoded by occupancy:
  - EMPTY (0): accept -> ONE with main_d=in_data. No accept -> EMPTY.
  - ONE (1):
    - emit & accept -> ONE, main_d=in_data.
    - emit & no accept -> EMPTY.
    - no emit & accept -> FULL, skid_d=in_data.
    - neither -> ONE, hold.
  - FULL (2): in_ready=0, so no accept. emit -> ONE with main_d=skid_d, skid cleared. No emit -> FULL, hold.
- Latency: 1 cycle from accept to out_valid when EMPTY. Throughput is 1 beat per cycle in steady state.
- Ordering: strict FIFO; the skid entry is never emitted ahead of main.
- Data stability: while out_valid=1 and out_ready=0, out_data is unchanged.
- Flush (priority over every other update):
  - Next state is EMPTY; in_ready=1 next cycle.
  - A beat accepted in the flush cycle is dropped.
  - An emit in the flush cycle still counts as delivered, since out_valid was already high.
  - out_valid drops on the following edge, not combinationally.
- Simultaneous events: flush with emit and accept -> EMPTY. Reset mid-transfer -> immediate EMPTY; no partial payload is ever visible.
- in_data is sampled only on accept; X on in_data while in_valid=0 must never reach out_data.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Defined: adds perf_stall_cnt and perf_bubble_cnt.
  - perf_stall_cnt increments each cycle with out_valid=1 & out_ready=0.
  - perf_bubble_cnt increments each cycle with out_valid=0 & flush=0.
  - Both are saturating at 2^CNT_W-1, cleared only by rst, and unaffected by flush.
- Undefined: both ports and all counter logic are absent; handshake behaviour is identical.

Test Plan:
- Reset then stream: in_valid=1, in_data=1..8 on consecutive cycles, out_ready=1 -> out_valid high from cycle 1, out_data=1..8 in order, occupancy stays 1, in_ready stays 1.
- Backpressure: send 0xA then 0xB with out_ready=0 -> occupancy=2, in_ready=0, out_data held at 0xA. Raise out_ready -> 0xA then 0xB emitted, in_ready returns to 1 one cycle after the first emit.
- Flush while FULL with simultaneous in_valid (data 0xC) -> next cycle out_valid=0, out_data=NOP_VALUE, occupancy=0. 0xC never appears.
- Async reset asserted mid-cycle while occupancy=2 -> out_valid=0 and in_ready=0 immediately, without a clock edge. After release, in_ready=1 and no stale data is emitted.
- Bubble encoding: DATA_W=8, NOP_VALUE=8'h13, in_data=8'hXX with in_valid=0 -> out_data=8'h13 and out_valid=0 every cycle.
- PIPE_STAGE_PERF_EN, CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles -> perf_stall_cnt saturates at 15. Then flush -> perf_stall_cnt remains 15.
